// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer
//   Drives an external combinational one-bit ALU slice bit-serially, LSB
//   first, to produce a WIDTH-bit AND/OR/XOR/ADD result. Operands, function
//   code and initial carry are captured on a start strobe in IDLE; the slice's
//   carry-out is looped back through c_q as the next bit's carry-in, and the
//   result bits are collected in a right-shifting register.
//
// Ports
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   start_i                   start request, honoured only in IDLE
//   a_i, b_i, f_i, carry_in_i operands, function code, initial carry
//   alu_a_o, alu_b_o,
//   alu_carry_o, alu_f_o      bit pair, carry and function to the slice
//   alu_result_i, alu_carry_i result and carry-out from the slice
//   ready_o / busy_o / done_o IDLE / RUN / one-cycle DONE indication
//   result_o, carry_o, zero_o last completed result, ADD carry, result==0
module serial_alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       f_i,
  input  logic             carry_in_i,
  output logic             alu_a_o,
  output logic             alu_b_o,
  output logic             alu_carry_o,
  output logic [3:0]       alu_f_o,
  input  logic             alu_result_i,
  input  logic             alu_carry_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [3:0]       f_q, f_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] res_next;

  // Result register after this edge's slice bit is shifted in at the MSB;
  // after WIDTH shifts bit 0 of the operation has reached position 0.
  assign res_next = {alu_result_i, res_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    f_d      = f_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    res_sr_d = res_sr_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sr_d   = a_i;
          b_sr_d   = b_i;
          f_d      = f_i;
          c_d      = carry_in_i;
          cnt_d    = '0;
          res_sr_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_sr_d = res_next;
        c_d      = alu_carry_i;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        if (cnt_q == LAST_BIT) begin
          // Counter parks on the last bit instead of wrapping; it is
          // cleared again on the next accepted start.
          state_d  = DONE;
          result_d = res_next;
          carry_d  = alu_carry_i & (f_q[1:0] == 2'b11);
          zero_d   = (res_next == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      f_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      res_sr_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      f_q      <= f_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      res_sr_q <= res_sr_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // Slice drive comes straight from registers so the slice path is a
  // single flop-to-flop cycle.
  assign alu_a_o     = a_sr_q[0];
  assign alu_b_o     = b_sr_q[0];
  assign alu_carry_o = c_q;
  assign alu_f_o     = f_q;

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;

endmodule
